// File: rtl/mips_ctl_pkg.sv
// Shared constants and the EX control bundle for the MIPS-I decode/control pipe.
// Build option: MIPS_MULDIV_EN adds mult/div and HI/LO move decoding.
package mips_ctl_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    // REGIMM rt codes
    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // alu_op one-hot bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_SLT  = 6;
    localparam int ALU_SLTU = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;

    // branch_op codes
    localparam logic [3:0] BR_NONE   = 4'd0;
    localparam logic [3:0] BR_BEQ    = 4'd1;
    localparam logic [3:0] BR_BNE    = 4'd2;
    localparam logic [3:0] BR_BLEZ   = 4'd3;
    localparam logic [3:0] BR_BGTZ   = 4'd4;
    localparam logic [3:0] BR_BLTZ   = 4'd5;
    localparam logic [3:0] BR_BGEZ   = 4'd6;
    localparam logic [3:0] BR_BLTZAL = 4'd7;
    localparam logic [3:0] BR_BGEZAL = 4'd8;

    // bsrc: ALU B operand source
    localparam logic [1:0] BSRC_RT   = 2'd0;
    localparam logic [1:0] BSRC_SIMM = 2'd1;  // sign-extended imm16
    localparam logic [1:0] BSRC_ZIMM = 2'd2;  // zero-extended imm16
    localparam logic [1:0] BSRC_UIMM = 2'd3;  // imm16 << 16 (lui)

    // shift_src: shift amount source, or HI/LO unit selector when the
    // ALU one-hot is all zero. In the HI/LO modes bsrc carries the sub-op:
    //   SH_MD_UNIT: bsrc[1]=divide, bsrc[0]=unsigned
    //   SH_HILO   : bsrc[1]=move to HI/LO, bsrc[0]=LO selected
    localparam logic [1:0] SH_SHAMT   = 2'd0;
    localparam logic [1:0] SH_RS      = 2'd1;
    localparam logic [1:0] SH_MD_UNIT = 2'd2;
    localparam logic [1:0] SH_HILO    = 2'd3;

    // load_mode and dmc
    localparam logic [1:0] LM_BYTE   = 2'd0;
    localparam logic [1:0] LM_HALF   = 2'd1;
    localparam logic [1:0] LM_WORD   = 2'd2;
    localparam logic [1:0] DMC_NONE  = 2'd0;
    localparam logic [1:0] DMC_LOAD  = 2'd1;
    localparam logic [1:0] DMC_STORE = 2'd2;

    typedef struct packed {
        logic [10:0] alu_op;
        logic [3:0]  branch_op;
        logic [1:0]  bsrc;
        logic [1:0]  shift_src;
        logic        jump;
        logic        jump_src;    // 0: target field, 1: rs register
        logic        mem_read;
        logic        mem_signed;
        logic [1:0]  load_mode;
        logic [1:0]  dmc;
        logic        wb_src;      // 0: ALU/link, 1: memory
        logic        wb_enable;
    } ctl_t;

    localparam int CTL_W = $bits(ctl_t);

    function automatic logic [10:0] alu_bit(input int pos);
        return 11'(1) << pos;
    endfunction

endpackage

// File: rtl/mips_ctl_decode.sv
// Pure combinational MIPS-I decode: instruction word to control bundle,
// resolved destination, illegal flag and whether rt is a source operand.
// Build option: MIPS_MULDIV_EN enables mult/div and HI/LO moves.
module mips_ctl_decode
    import mips_ctl_pkg::*;
(
    input  logic [31:0] ins_i,
    output ctl_t        ctl_o,
    output logic [4:0]  dest_o,
    output logic        illegal_o,
    output logic        reads_rt_o
);

    logic [5:0] op;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    ctl_t       c;
    logic [4:0] dest;
    logic       wb;
    logic       ill;
    logic       rrt;
    logic       unused_bits;

    assign op    = ins_i[31:26];
    assign rt    = ins_i[20:16];
    assign rd    = ins_i[15:11];
    assign funct = ins_i[5:0];
    assign unused_bits = ^{ins_i[25:21], ins_i[10:6]};

    // Field decode; write-back is dropped for $0 and everything is zeroed for illegal words
    always_comb begin
        c    = '0;
        dest = 5'd0;
        wb   = 1'b0;
        ill  = 1'b0;
        rrt  = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
                        case (funct)
                            F_SLL, F_SLLV: c.alu_op = alu_bit(ALU_SLL);
                            F_SRL, F_SRLV: c.alu_op = alu_bit(ALU_SRL);
                            default:       c.alu_op = alu_bit(ALU_SRA);
                        endcase
                        c.shift_src = funct[2] ? SH_RS : SH_SHAMT;
                        rrt  = 1'b1;
                        wb   = 1'b1;
                        dest = rd;
                    end
                    F_JR: begin
                        c.jump     = 1'b1;
                        c.jump_src = 1'b1;
                    end
                    F_JALR: begin
                        c.jump     = 1'b1;
                        c.jump_src = 1'b1;
                        wb   = 1'b1;
                        dest = rd;
                    end
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
                        case (funct)
                            F_ADD, F_ADDU: c.alu_op = alu_bit(ALU_ADD);
                            F_SUB, F_SUBU: c.alu_op = alu_bit(ALU_SUB);
                            F_AND:         c.alu_op = alu_bit(ALU_AND);
                            F_OR:          c.alu_op = alu_bit(ALU_OR);
                            F_XOR:         c.alu_op = alu_bit(ALU_XOR);
                            F_NOR:         c.alu_op = alu_bit(ALU_NOR);
                            F_SLT:         c.alu_op = alu_bit(ALU_SLT);
                            default:       c.alu_op = alu_bit(ALU_SLTU);
                        endcase
                        c.bsrc = BSRC_RT;
                        rrt  = 1'b1;
                        wb   = 1'b1;
                        dest = rd;
                    end
`ifdef MIPS_MULDIV_EN
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        c.shift_src = SH_MD_UNIT;
                        c.bsrc      = funct[1:0];
                        rrt = 1'b1;
                    end
                    F_MFHI, F_MFLO: begin
                        c.shift_src = SH_HILO;
                        c.bsrc      = {1'b0, funct[1]};
                        wb   = 1'b1;
                        dest = rd;
                    end
                    F_MTHI, F_MTLO: begin
                        c.shift_src = SH_HILO;
                        c.bsrc      = {1'b1, funct[1]};
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ:   c.branch_op = BR_BLTZ;
                    RT_BGEZ:   c.branch_op = BR_BGEZ;
                    RT_BLTZAL: begin
                        c.branch_op = BR_BLTZAL;
                        wb   = 1'b1;
                        dest = 5'd31;
                    end
                    RT_BGEZAL: begin
                        c.branch_op = BR_BGEZAL;
                        wb   = 1'b1;
                        dest = 5'd31;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_J: c.jump = 1'b1;
            OP_JAL: begin
                c.jump = 1'b1;
                wb   = 1'b1;
                dest = 5'd31;
            end
            OP_BEQ, OP_BNE: begin
                c.alu_op    = alu_bit(ALU_SUB);
                c.branch_op = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
                rrt = 1'b1;
            end
            OP_BLEZ: c.branch_op = BR_BLEZ;
            OP_BGTZ: c.branch_op = BR_BGTZ;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                case (op)
                    OP_ADDI, OP_ADDIU: begin c.alu_op = alu_bit(ALU_ADD);  c.bsrc = BSRC_SIMM; end
                    OP_SLTI:           begin c.alu_op = alu_bit(ALU_SLT);  c.bsrc = BSRC_SIMM; end
                    OP_SLTIU:          begin c.alu_op = alu_bit(ALU_SLTU); c.bsrc = BSRC_SIMM; end
                    OP_ANDI:           begin c.alu_op = alu_bit(ALU_AND);  c.bsrc = BSRC_ZIMM; end
                    OP_ORI:            begin c.alu_op = alu_bit(ALU_OR);   c.bsrc = BSRC_ZIMM; end
                    OP_XORI:           begin c.alu_op = alu_bit(ALU_XOR);  c.bsrc = BSRC_ZIMM; end
                    default:           begin c.alu_op = alu_bit(ALU_OR);   c.bsrc = BSRC_UIMM; end
                endcase
                wb   = 1'b1;
                dest = rt;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                c.alu_op     = alu_bit(ALU_ADD);
                c.bsrc       = BSRC_SIMM;
                c.mem_read   = 1'b1;
                c.mem_signed = ~op[2];
                c.load_mode  = (op[1:0] == 2'b00) ? LM_BYTE :
                               (op[1:0] == 2'b01) ? LM_HALF : LM_WORD;
                c.dmc        = DMC_LOAD;
                c.wb_src     = 1'b1;
                wb   = 1'b1;
                dest = rt;
            end
            OP_SB, OP_SH, OP_SW: begin
                c.alu_op    = alu_bit(ALU_ADD);
                c.bsrc      = BSRC_SIMM;
                c.load_mode = (op[1:0] == 2'b00) ? LM_BYTE :
                              (op[1:0] == 2'b01) ? LM_HALF : LM_WORD;
                c.dmc       = DMC_STORE;
                rrt = 1'b1;
            end
            default: ill = 1'b1;
        endcase

        c.wb_enable = wb & (dest != 5'd0);
        if (ill) begin
            c    = '0;
            dest = 5'd0;
            rrt  = 1'b0;
        end
    end

    assign ctl_o      = c;
    assign dest_o     = dest;
    assign illegal_o  = ill;
    assign reads_rt_o = rrt;

endmodule

// File: rtl/decode_ctl_pipe.sv
// RD->EX decode/control pipeline register with load-use and mult/div
// interlocks. Build option: MIPS_MULDIV_EN (mult/div decode + busy counter).
module decode_ctl_pipe
    import mips_ctl_pkg::*;
#(
    parameter int INS_W      = 32,
    parameter int MULDIV_LAT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ins_valid_rd,
    input  logic [INS_W-1:0] ins_rd,
    output logic             ins_ready_rd,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             valid_ex,
    output logic [CTL_W-1:0] ctl_ex,
    output logic [4:0]       dest_ex,
    output logic             illegal_ex
);

    ctl_t       dec_ctl;
    logic [4:0] dec_dest;
    logic       dec_illegal;
    logic       dec_reads_rt;

    logic       valid_q, valid_d;
    ctl_t       ctl_q, ctl_d;
    logic [4:0] dest_q, dest_d;
    logic       illegal_q, illegal_d;

    logic       load_use;
    logic       muldiv_stall;
    logic       accept;
    logic [4:0] rs_rd;
    logic [4:0] rt_rd;

    mips_ctl_decode u_decode (
        .ins_i      (ins_rd),
        .ctl_o      (dec_ctl),
        .dest_o     (dec_dest),
        .illegal_o  (dec_illegal),
        .reads_rt_o (dec_reads_rt)
    );

    assign rs_rd = ins_rd[25:21];
    assign rt_rd = ins_rd[20:16];

    // A load in EX whose result feeds the RD instruction forces one bubble
    assign load_use = valid_q & ctl_q.mem_read & (dest_q != 5'd0) &
                      ((dest_q == rs_rd) | (dec_reads_rt & (dest_q == rt_rd)));

    assign ins_ready_rd = ex_ready & ~flush & ~load_use & ~muldiv_stall;
    assign accept       = ins_valid_rd & ins_ready_rd;

`ifdef MIPS_MULDIV_EN
    logic [6:0] md_cnt_q, md_cnt_d;
    logic       md_start;
    logic       md_user;

    assign md_start = (dec_ctl.shift_src == SH_MD_UNIT) & (dec_ctl.alu_op == '0) & ~dec_illegal;
    assign md_user  = (dec_ctl.shift_src[1] == 1'b1) & (dec_ctl.alu_op == '0) & ~dec_illegal;
    assign muldiv_stall = (md_cnt_q != 7'd0) & md_user;

    // Busy counter: reload on an accepted mult/div, otherwise count down to 0
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (accept && md_start) begin
            md_cnt_d = 7'(MULDIV_LAT - 1);
        end else if (md_cnt_q != 7'd0) begin
            md_cnt_d = md_cnt_q - 7'd1;
        end
    end

    // Busy counter register; only reset clears it, flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= 7'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg   = ^MULDIV_LAT;
    assign muldiv_stall = 1'b0;
`endif

    // EX slot next state: flush kills, advance loads or bubbles, stall holds
    always_comb begin
        valid_d   = valid_q;
        ctl_d     = ctl_q;
        dest_d    = dest_q;
        illegal_d = illegal_q;
        if (flush) begin
            valid_d   = 1'b0;
            ctl_d     = '0;
            dest_d    = 5'd0;
            illegal_d = 1'b0;
        end else if (ex_ready) begin
            if (accept) begin
                valid_d   = 1'b1;
                ctl_d     = dec_ctl;
                dest_d    = dec_dest;
                illegal_d = dec_illegal;
            end else begin
                valid_d   = 1'b0;
                ctl_d     = '0;
                dest_d    = 5'd0;
                illegal_d = 1'b0;
            end
        end
    end

    // EX slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctl_q     <= '0;
            dest_q    <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctl_q     <= ctl_d;
            dest_q    <= dest_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_ex   = valid_q;
    assign ctl_ex     = ctl_q;
    assign dest_ex    = dest_q;
    assign illegal_ex = illegal_q;

endmodule

// File: tb/tb_decode_ctl_pipe.sv
// Directed bench for decode_ctl_pipe (MULDIV_LAT=4). Mult/div sequences run
// when MIPS_MULDIV_EN is defined; otherwise those encodings must be illegal.
module tb_decode_ctl_pipe;
    import mips_ctl_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             ins_valid_rd;
    logic [31:0]      ins_rd;
    logic             ins_ready_rd;
    logic             ex_ready;
    logic             flush;
    logic             valid_ex;
    logic [CTL_W-1:0] ctl_ex;
    logic [4:0]       dest_ex;
    logic             illegal_ex;
    ctl_t             cv;

    int n_vec = 0;
    int n_err = 0;

    decode_ctl_pipe #(.INS_W(32), .MULDIV_LAT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ins_valid_rd (ins_valid_rd),
        .ins_rd       (ins_rd),
        .ins_ready_rd (ins_ready_rd),
        .ex_ready     (ex_ready),
        .flush        (flush),
        .valid_ex     (valid_ex),
        .ctl_ex       (ctl_ex),
        .dest_ex      (dest_ex),
        .illegal_ex   (illegal_ex)
    );

    assign cv = ctl_t'(ctl_ex);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ins_valid_rd = 1'b0; ins_rd = 32'h0; ex_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_ex, 0);
        chk("rst_ctl", ctl_ex, 0);
        chk("rst_dest", dest_ex, 0);
        chk("rst_illegal", illegal_ex, 0);
        rst_n = 1'b1; ex_ready = 1'b1; #1;
        chk("post_rst_ready", ins_ready_rd, 1);
        ex_ready = 1'b0; #1;
        chk("post_rst_ready_lo", ins_ready_rd, 0);
        ex_ready = 1'b1;

        // lw $8 then dependent add: one bubble
        ins_valid_rd = 1'b1; ins_rd = 32'h8D280000; #1;
        chk("lw_ready", ins_ready_rd, 1);
        tick();
        chk("lw_valid", valid_ex, 1);
        chk("lw_dest", dest_ex, 8);
        chk("lw_memrd", cv.mem_read, 1);
        chk("lw_mode", cv.load_mode, 2);
        chk("lw_wbsrc", cv.wb_src, 1);
        ins_rd = 32'h010B5020; #1;
        chk("lu_stall", ins_ready_rd, 0);
        tick();
        chk("lu_bubble", valid_ex, 0);
        chk("lu_bubble_ctl", ctl_ex, 0);
        chk("lu_ready", ins_ready_rd, 1);
        tick();
        chk("add_valid", valid_ex, 1);
        chk("add_dest", dest_ex, 10);
        chk("add_alu", cv.alu_op, 11'h001);
        chk("add_wb", cv.wb_enable, 1);

        // jal
        ins_rd = 32'h0C000000; tick();
        chk("jal_valid", valid_ex, 1);
        chk("jal_dest", dest_ex, 31);
        chk("jal_jump", cv.jump, 1);
        chk("jal_wb", cv.wb_enable, 1);

        // undecodable word
        ins_rd = 32'hFC000000; tick();
        chk("ill_valid", valid_ex, 1);
        chk("ill_flag", illegal_ex, 1);
        chk("ill_wb", cv.wb_enable, 0);
        chk("ill_memrd", cv.mem_read, 0);
        chk("ill_dmc", cv.dmc, 0);

        // addi $0,$0,5: write to $0 suppressed
        ins_rd = 32'h20000005; tick();
        chk("r0_wb", cv.wb_enable, 0);
        chk("r0_alu", cv.alu_op, 11'h001);
        chk("r0_ill", illegal_ex, 0);

        // ori $3,$4,0x12
        ins_rd = 32'h34830012; tick();
        chk("ori_alu", cv.alu_op, 11'h008);
        chk("ori_bsrc", cv.bsrc, 2);
        chk("ori_dest", dest_ex, 3);

        // sw $8,4($9)
        ins_rd = 32'hAD280004; tick();
        chk("sw_dmc", cv.dmc, 2);
        chk("sw_wb", cv.wb_enable, 0);
        chk("sw_memrd", cv.mem_read, 0);

        // lb $5 then rt-only consumers
        ins_rd = 32'h80C50000; tick();
        chk("lb_signed", cv.mem_signed, 1);
        chk("lb_mode", cv.load_mode, 0);
        chk("lb_dest", dest_ex, 5);
        ins_rd = 32'h20E50001; #1;
        chk("addi_rt_no_use", ins_ready_rd, 1);
        ins_rd = 32'hACE50000; #1;
        chk("sw_rt_use", ins_ready_rd, 0);
        tick();
        chk("sw_bubble", valid_ex, 0);
        tick();
        chk("sw2_valid", valid_ex, 1);
        chk("sw2_dmc", cv.dmc, 2);

        // bltzal links to $31
        ins_rd = 32'h04100000; tick();
        chk("bltzal_br", cv.branch_op, 7);
        chk("bltzal_dest", dest_ex, 31);
        chk("bltzal_wb", cv.wb_enable, 1);

        // stall 3 cycles with add in EX, then flush
        ins_rd = 32'h010B5020; tick();
        chk("hold_pre_valid", valid_ex, 1);
        ex_ready = 1'b0; ins_rd = 32'h0C000000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", ins_ready_rd, 0);
            tick();
            chk("hold_valid", valid_ex, 1);
            chk("hold_dest", dest_ex, 10);
            chk("hold_alu", cv.alu_op, 11'h001);
        end
        flush = 1'b1; #1;
        chk("flush_ready", ins_ready_rd, 0);
        tick();
        chk("flush_valid", valid_ex, 0);
        chk("flush_ill", illegal_ex, 0);
        flush = 1'b0; ex_ready = 1'b1;

        // flush beats acceptance and clears illegal
        ins_rd = 32'hFC000000; tick();
        chk("pre_flush_ill", illegal_ex, 1);
        flush = 1'b1; tick();
        chk("flush_acc_valid", valid_ex, 0);
        chk("flush_acc_ill", illegal_ex, 0);
        flush = 1'b0;

        // asynchronous reset mid-cycle
        ins_rd = 32'h34830012; tick();
        chk("ares_pre", valid_ex, 1);
        #2 rst_n = 1'b0; #1;
        chk("ares_valid", valid_ex, 0);
        chk("ares_ctl", ctl_ex, 0);
        chk("ares_dest", dest_ex, 0);
        #3 rst_n = 1'b1; tick();
        chk("ares_after", valid_ex, 1);
        chk("ares_after_dest", dest_ex, 3);

`ifdef MIPS_MULDIV_EN
        // mult then mfhi: mfhi accepted 4 cycles after mult
        ins_rd = 32'h01090018; #1;
        chk("mult_ready", ins_ready_rd, 1);
        tick();
        chk("mult_valid", valid_ex, 1);
        chk("mult_ill", illegal_ex, 0);
        ins_rd = 32'h00001010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mfhi_stall", ins_ready_rd, 0);
            tick();
            chk("mfhi_bubble", valid_ex, 0);
        end
        #1;
        chk("mfhi_ready", ins_ready_rd, 1);
        tick();
        chk("mfhi_valid", valid_ex, 1);
        chk("mfhi_dest", dest_ex, 2);
        chk("mfhi_wb", cv.wb_enable, 1);

        // reset in the middle of the mult/div stall
        ins_rd = 32'h01090018; tick();
        ins_rd = 32'h00001010; #1;
        chk("md2_stall", ins_ready_rd, 0);
        tick();
        #2 rst_n = 1'b0; #1;
        chk("md_rst_valid", valid_ex, 0);
        chk("md_rst_ctl", ctl_ex, 0);
        chk("md_rst_dest", dest_ex, 0);
        chk("md_rst_ill", illegal_ex, 0);
        #3 rst_n = 1'b1; #1;
        chk("md_rst_ready", ins_ready_rd, 1);
        tick();
        chk("md_rst_mfhi_valid", valid_ex, 1);
        chk("md_rst_mfhi_dest", dest_ex, 2);
`else
        // without mult/div support these encodings are illegal
        ins_rd = 32'h01090018; tick();
        chk("mult_illegal", illegal_ex, 1);
        chk("mult_ill_valid", valid_ex, 1);
        ins_rd = 32'h00001010; #1;
        chk("mfhi_no_stall", ins_ready_rd, 1);
        tick();
        chk("mfhi_illegal", illegal_ex, 1);
        chk("mfhi_ill_wb", cv.wb_enable, 0);
`endif

        ins_valid_rd = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
